// File: rtl/msm_pkg.sv
// msm_pkg: shared types for the MSM accumulator slice.
//   W            default coordinate width; a point is {x,y}, 2*W bits
//   DEPTH/CNT_W  default buffer depth and point-counter width
//   point_t      affine point {x,y}
//   acc_state_t  accumulator FSM states
package msm_pkg;

  localparam int W     = 256;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ADD,
    FIN
  } acc_state_t;

endpackage

// File: rtl/msm_point_fifo.sv
// msm_point_fifo: synchronous show-ahead FIFO holding point_mul results.
// Ports:
//   clk, Reset           clock, synchronous active-high reset (flushes pointers)
//   push, push_data      write strobe / data; a push while full is taken only
//                        when a pop happens in the same cycle
//   pop, pop_data        read strobe / head entry (valid while !empty)
//   full, empty          occupancy flags
module msm_point_fifo #(
  parameter int DW    = 512,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being read this cycle;
  // the reader sees the old contents because mem_q updates on the edge.
  assign do_push = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/msm_accumulator.sv
// msm_accumulator: sums the k*P results of one MSM job through an external
// point adder and reports the final affine sum plus a point-at-infinity flag.
// Ports:
//   clk, Reset            clock, synchronous active-high reset
//   start, num_points     job launch (sampled in IDLE only) and point count
//   in_valid/in_point     point_mul results; accepted when in_ready is high
//   in_ready              busy and buffer not full
//   add_start/add_a/add_b adder request; operands held until add_done
//   add_done/add_r        adder response (ignored outside WAIT_ADD)
//   sum/sum_inf/done      final result, held until the next job completes
//   busy                  any state other than IDLE
//   err                   sticky doubling error (equal-point detection only)
// Build option: MSM_ACC_EQUAL_DETECT_EN enables the equal-x comparator that
// resolves P+(-P) locally and flags P+P as an error; without it err is 0 and
// every pair goes to the adder.
//
// state    | meaning
// IDLE     | waiting for start; input dropped
// LOAD     | pop next buffered point or finish when all points absorbed
// ISSUE    | one-cycle add_start pulse
// WAIT_ADD | operands held, waiting for add_done
// FIN      | one-cycle done pulse with sum valid
module msm_accumulator
  import msm_pkg::*;
#(
  parameter int W     = msm_pkg::W,
  parameter int DEPTH = msm_pkg::DEPTH,
  parameter int CNT_W = msm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_points,
  input  logic             in_valid,
  input  logic [2*W-1:0]   in_point,
  output logic             in_ready,
  output logic             add_start,
  output logic [2*W-1:0]   add_a,
  output logic [2*W-1:0]   add_b,
  input  logic             add_done,
  input  logic [2*W-1:0]   add_r,
  output logic [2*W-1:0]   sum,
  output logic             sum_inf,
  output logic             done,
  output logic             busy,
  output logic             err
);

  acc_state_t       state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic             acc_inf_q, acc_inf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [2*W-1:0]   bpt_q, bpt_d;
  logic [2*W-1:0]   sum_q, sum_d;
  logic             sum_inf_q, sum_inf_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*W-1:0]   fifo_rd;

  assign busy      = (state_q != IDLE);
  assign in_ready  = busy & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  // Gated by Reset so the pulse drops in the reset cycle itself.
  assign add_start = (state_q == ISSUE) & ~Reset;
  assign add_a     = acc_q;
  assign add_b     = bpt_q;
  assign sum       = sum_q;
  assign sum_inf   = sum_inf_q;
  assign done      = (state_q == FIN);

  msm_point_fifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (in_point),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MSM_ACC_EQUAL_DETECT_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_inf_d = acc_inf_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    bpt_d     = bpt_q;
    sum_d     = sum_q;
    sum_inf_d = sum_inf_q;
    fifo_pop  = 1'b0;
`ifdef MSM_ACC_EQUAL_DETECT_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d     = num_points;
          cnt_d     = '0;
          acc_d     = '0;
          acc_inf_d = 1'b1;
`ifdef MSM_ACC_EQUAL_DETECT_EN
          err_d     = 1'b0;
`endif
          if (num_points == '0) begin
            // Empty job: the result is the cleared accumulator.
            sum_d     = '0;
            sum_inf_d = 1'b1;
            state_d   = FIN;
          end else begin
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        // sum is captured on the way into FIN so it is valid alongside done.
        if (cnt_q == num_q) begin
          sum_d     = acc_q;
          sum_inf_d = acc_inf_q;
          state_d   = FIN;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (acc_inf_q) begin
            acc_d     = fifo_rd;
            acc_inf_d = 1'b0;
          end
`ifdef MSM_ACC_EQUAL_DETECT_EN
          else if (fifo_rd[2*W-1:W] == acc_q[2*W-1:W]) begin
            if (fifo_rd[W-1:0] != acc_q[W-1:0]) begin
              acc_inf_d = 1'b1;
            end else begin
              err_d     = 1'b1;
            end
          end
`endif
          else begin
            bpt_d   = fifo_rd;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_ADD;
      end
      WAIT_ADD: begin
        if (add_done) begin
          acc_d   = add_r;
          state_d = LOAD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      acc_inf_q <= 1'b1;
      cnt_q     <= '0;
      num_q     <= '0;
      bpt_q     <= '0;
      sum_q     <= '0;
      sum_inf_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_inf_q <= acc_inf_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      bpt_q     <= bpt_d;
      sum_q     <= sum_d;
      sum_inf_q <= sum_inf_d;
    end
  end

`ifdef MSM_ACC_EQUAL_DETECT_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_msm_accumulator.sv
// tb_msm_accumulator: directed bench for msm_accumulator. A behavioural
// adder for y^2 = x^3 + 2x + 2 (mod 17) answers add_start; expected job
// results are queued when a job is launched and compared when done fires.
module tb_msm_accumulator;

  localparam int W     = 256;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int PW    = 2*W;

  logic             clk = 1'b0;
  logic             Reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_points = '0;
  logic             in_valid = 1'b0;
  logic [PW-1:0]    in_point = '0;
  logic             in_ready;
  logic             add_start;
  logic [PW-1:0]    add_a, add_b;
  logic             add_done = 1'b0;
  logic [PW-1:0]    add_r = '0;
  logic [PW-1:0]    sum;
  logic             sum_inf, done, busy, err;

  always #5 clk = ~clk;

  msm_accumulator #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .num_points (num_points),
    .in_valid   (in_valid),
    .in_point   (in_point),
    .in_ready   (in_ready),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_done   (add_done),
    .add_r      (add_r),
    .sum        (sum),
    .sum_inf    (sum_inf),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  typedef struct packed {
    logic [PW-1:0] sum;
    logic          inf;
    logic          err;
    logic          chk_sum;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [PW-1:0] job_pts[$];
  int            pass_cnt = 0;
  int            check_cnt = 0;
  int            done_cnt = 0;
  int            add_start_cnt = 0;
  int            adder_lat = 2;
  bit            adder_mute = 1'b0;
  logic [PW-1:0] a_s, b_s;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // ---------------- curve arithmetic mod 17 ----------------
  function automatic int md(input int v);
    return ((v % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int v);
    int r = 0;
    for (int i = 1; i < 17; i++) if (md(v * i) == 1) r = i;
    return r;
  endfunction

  function automatic logic [PW-1:0] pt(input int x, input int y);
    return {W'(x), W'(y)};
  endfunction

  // Infinity has no affine encoding; the model answers 0 for P+(-P).
  function automatic logic [PW-1:0] ec_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int x1, y1, x2, y2, l, x3, y3;
    x1 = int'(a[W+7:W]); y1 = int'(a[7:0]);
    x2 = int'(b[W+7:W]); y2 = int'(b[7:0]);
    if (x1 == x2 && y1 != y2) return '0;
    if (x1 == x2) l = md((3*x1*x1 + 2) * inv(2*y1));
    else          l = md((y2 - y1) * inv(x2 - x1));
    x3 = md(l*l - x1 - x2);
    y3 = md(l*(x1 - x3) - y1);
    return pt(x3, y3);
  endfunction

  function automatic exp_t mk_exp(input logic [PW-1:0] s, input logic inf, input logic e, input logic cs);
    exp_t r;
    r.sum = s; r.inf = inf; r.err = e; r.chk_sum = cs;
    return r;
  endfunction

  // ---------------- adder model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (add_start && !adder_mute) begin
        a_s = add_a;
        b_s = add_b;
        repeat (adder_lat - 1) begin
          @(negedge clk);
          check("add_a_stable", add_a, a_s);
          check("add_b_stable", add_b, b_s);
        end
        add_r    = ec_add(a_s, b_s);
        add_done = 1'b1;
        @(negedge clk);
        add_done = 1'b0;
        add_r    = '0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (add_start) add_start_cnt++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_without_job", PW'(exp_q.size()), PW'(1));
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_sum) check("sum", sum, mon_e.sum);
        check("sum_inf", PW'(sum_inf), PW'(mon_e.inf));
        check("err", PW'(err), PW'(mon_e.err));
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic push_pt(input logic [PW-1:0] p);
    int guard = 0;
    in_point = p;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", PW'(in_ready), PW'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input exp_t e, input int exp_adds, input int budget,
                         input bit chk_full, input string tag);
    int base_done, base_add, n;
    base_done = done_cnt;
    base_add  = add_start_cnt;
    exp_q.push_back(e);
    start      = 1'b1;
    num_points = CNT_W'(job_pts.size());
    @(negedge clk);
    start = 1'b0;
    foreach (job_pts[i]) push_pt(job_pts[i]);
    if (chk_full) check({tag, "_ready_low_full"}, PW'(in_ready), PW'(0));
    n = 0;
    while (done_cnt == base_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_count"}, PW'(done_cnt - base_done), PW'(1));
    check({tag, "_add_starts"}, PW'(add_start_cnt - base_add), PW'(exp_adds));
    @(negedge clk);
    check({tag, "_idle_after"}, PW'(busy), PW'(0));
    job_pts.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [PW-1:0] p1, p2, model;
    int base_done, base_add, n;
    p1 = pt(5, 1);
    p2 = pt(6, 3);

    repeat (3) @(negedge clk);
    check("rst_busy", PW'(busy), PW'(0));
    check("rst_done", PW'(done), PW'(0));
    check("rst_sum", sum, '0);
    check("rst_sum_inf", PW'(sum_inf), PW'(1));
    check("rst_in_ready", PW'(in_ready), PW'(0));
    check("rst_add_start", PW'(add_start), PW'(0));
    check("rst_err", PW'(err), PW'(0));
    Reset = 1'b0;
    @(negedge clk);

    // 1: single point, no adder call
    job_pts.push_back(p1);
    run_job(mk_exp(p1, 1'b0, 1'b0, 1'b1), 0, 20, 1'b0, "t1");

    // 2: P + 2P + P = 4P = (3,1)
    job_pts.push_back(p1); job_pts.push_back(p2); job_pts.push_back(p1);
    run_job(mk_exp(pt(3, 1), 1'b0, 1'b0, 1'b1), 2, 60, 1'b0, "t2");

    // 3: empty job
    run_job(mk_exp('0, 1'b1, 1'b0, 1'b1), 0, 3, 1'b0, "t3");

    // 4: six back-to-back points against a slow adder
    adder_lat = 6;
    for (int i = 0; i < 6; i++) job_pts.push_back((i % 2 == 0) ? p1 : p2);
    model = job_pts[0];
    for (int i = 1; i < 6; i++) model = ec_add(model, job_pts[i]);
    run_job(mk_exp(model, 1'b0, 1'b0, 1'b1), 5, 200, 1'b1, "t4");
    adder_lat = 2;

    // 5: reset while waiting on the adder, then a stale add_done
    adder_mute = 1'b1;
    base_done  = done_cnt;
    start      = 1'b1;
    num_points = CNT_W'(2);
    @(negedge clk);
    start = 1'b0;
    push_pt(p1);
    push_pt(p2);
    n = 0;
    while (!add_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_issue", PW'(add_start), PW'(1));
    @(negedge clk);
    check("t5_busy_in_wait", PW'(busy), PW'(1));
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("t5_busy_after_rst", PW'(busy), PW'(0));
    base_add = add_start_cnt;
    add_r    = pt(1, 1);
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
    add_r    = '0;
    repeat (10) @(negedge clk);
    check("t5_no_done", PW'(done_cnt - base_done), PW'(0));
    check("t5_no_add_start", PW'(add_start_cnt - base_add), PW'(0));
    check("t5_busy_idle", PW'(busy), PW'(0));
    check("t5_sum_inf_rst", PW'(sum_inf), PW'(1));
    adder_mute = 1'b0;

    // 6: equal-x operands
`ifdef MSM_ACC_EQUAL_DETECT_EN
    job_pts.push_back(p1); job_pts.push_back(pt(5, 16));
    run_job(mk_exp('0, 1'b1, 1'b0, 1'b0), 0, 20, 1'b0, "t6_neg");
    job_pts.push_back(p1); job_pts.push_back(p1);
    run_job(mk_exp(p1, 1'b0, 1'b1, 1'b1), 0, 20, 1'b0, "t6_dbl");
    job_pts.push_back(p2);
    run_job(mk_exp(p2, 1'b0, 1'b0, 1'b1), 0, 20, 1'b0, "t6_err_clear");
`else
    job_pts.push_back(p1); job_pts.push_back(pt(5, 16));
    run_job(mk_exp('0, 1'b0, 1'b0, 1'b0), 1, 30, 1'b0, "t6_neg");
    job_pts.push_back(p1); job_pts.push_back(p1);
    run_job(mk_exp(p2, 1'b0, 1'b0, 1'b1), 1, 30, 1'b0, "t6_dbl");
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", PW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
